sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 116 +++++++++++
 tb/tb_sram_controller.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// Bridges a 32-bit MEM-stage load/store onto a 16-bit asynchronous SRAM as two half-word beats.
// The pipeline is held (ready low) until the slow SRAM access has settled.
module sram_controller (
    input  logic        clk,
    input  logic        rst,
    input  logic        wr_en,
    input  logic        rd_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    inout  wire  [15:0] sram_dq,
    output logic [17:0] sram_addr,
    output logic        sram_we_n,
    output logic        sram_ub_n,
    output logic        sram_lb_n,
    output logic        sram_ce_n,
    output logic        sram_oe_n
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LO,
        S_HI,
        S_WAIT,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic        r_is_wr;
    logic [16:0] r_w;
    logic [15:0] r_wdata_hi;
    logic [15:0] r_dq_out;
    logic [17:0] r_addr;
    logic        r_we_n;
    logic        r_oe_n;
    logic [31:0] r_read_data;

    logic        w_req;
    logic [16:0] w_word;

    assign w_req  = wr_en | rd_en;
    assign w_word = 17'((address - 32'd1024) >> 2);

    // The data bus is only ever driven while a write beat is on the SRAM.
    assign sram_dq   = r_we_n ? 16'bz : r_dq_out;
    assign sram_addr = r_addr;
    assign sram_we_n = r_we_n;
    assign sram_oe_n = r_oe_n;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;
    assign sram_ce_n = 1'b0;
    assign read_data = r_read_data;

    assign ready = (r_state == S_DONE) || ((r_state == S_IDLE) && !w_req);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= 2'd0;
            r_is_wr     <= 1'b0;
            r_w         <= '0;
            r_wdata_hi  <= '0;
            r_dq_out    <= '0;
            r_addr      <= '0;
            r_we_n      <= 1'b1;
            r_oe_n      <= 1'b0;
            r_read_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_req) begin
                        // Both enables high resolves to a store.
                        r_state    <= S_LO;
                        r_is_wr    <= wr_en;
                        r_w        <= w_word;
                        r_wdata_hi <= write_data[31:16];
                        r_dq_out   <= write_data[15:0];
                        r_addr     <= {w_word, 1'b0};
                        r_we_n     <= ~wr_en;
                        r_oe_n     <= wr_en;
                    end
                end
                S_LO: begin
                    r_state  <= S_HI;
                    r_addr   <= {r_w, 1'b1};
                    r_dq_out <= r_wdata_hi;
                    if (!r_is_wr)
                        r_read_data[15:0] <= sram_dq;
                end
                S_HI: begin
                    r_state <= S_WAIT;
                    r_cnt   <= 2'd0;
                    r_we_n  <= 1'b1;
                    r_oe_n  <= 1'b0;
                    if (!r_is_wr)
                        r_read_data[31:16] <= sram_dq;
                end
                S_WAIT: begin
                    if (r_cnt == 2'd2)
                        r_state <= S_DONE;
                    else
                        r_cnt <= r_cnt + 2'd1;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller: an SRAM device model, a transaction-level
// reference model checked every cycle, and directed scenarios with literal expectations.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        wr_en;
    logic        rd_en;
    logic [31:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        ready;
    wire  [15:0] sram_dq;
    logic [17:0] sram_addr;
    logic        sram_we_n;
    logic        sram_ub_n;
    logic        sram_lb_n;
    logic        sram_ce_n;
    logic        sram_oe_n;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    always #5 clk = ~clk;

    sram_controller dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .rd_en      (rd_en),
        .address    (address),
        .write_data (write_data),
        .read_data  (read_data),
        .ready      (ready),
        .sram_dq    (sram_dq),
        .sram_addr  (sram_addr),
        .sram_we_n  (sram_we_n),
        .sram_ub_n  (sram_ub_n),
        .sram_lb_n  (sram_lb_n),
        .sram_ce_n  (sram_ce_n),
        .sram_oe_n  (sram_oe_n)
    );

    // SRAM device: drives the bus on reads, captures the bus on write-enabled edges.
    bit [15:0] sram_mem [0:1023];
    assign sram_dq = (!sram_ce_n && !sram_oe_n && sram_we_n) ? sram_mem[sram_addr[9:0]] : 16'bz;
    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n)
            sram_mem[sram_addr[9:0]] <= sram_dq;
    end

    function automatic int idx(input logic [16:0] w, input bit h);
        return int'({w[8:0], h});
    endfunction

    // Reference model: one accepted request occupies cycles 1..6 after acceptance;
    // beat 1 touches the low half-word, beat 2 the high half, cycle 6 releases the pipeline.
    bit [15:0]   ref_mem [0:1023];
    bit          m_active;
    int          m_n;
    bit          m_wr;
    logic [16:0] m_w;
    logic [31:0] m_data;
    logic [31:0] m_rd;
    logic [17:0] m_hold;

    always @(posedge clk) begin
        if (rst) begin
            m_active <= 1'b0;
            m_n      <= 0;
            m_w      <= '0;
            m_rd     <= '0;
            m_hold   <= '0;
        end else if (!m_active) begin
            if (wr_en || rd_en) begin
                m_active <= 1'b1;
                m_n      <= 1;
                m_wr     <= wr_en;
                m_w      <= 17'((address - 32'd1024) >> 2);
                m_data   <= write_data;
            end
        end else begin
            if (m_n == 1) begin
                if (m_wr) ref_mem[idx(m_w, 1'b0)] <= m_data[15:0];
                else      m_rd[15:0] <= ref_mem[idx(m_w, 1'b0)];
            end
            if (m_n == 2) begin
                if (m_wr) ref_mem[idx(m_w, 1'b1)] <= m_data[31:16];
                else      m_rd[31:16] <= ref_mem[idx(m_w, 1'b1)];
                m_hold <= {m_w, 1'b1};
            end
            if (m_n == 6) m_active <= 1'b0;
            else          m_n <= m_n + 1;
        end
    end

    logic        exp_ready;
    logic        exp_we_n;
    logic [17:0] exp_addr;
    logic [15:0] exp_dq;
    assign exp_ready = m_active ? (m_n == 6) : !(wr_en || rd_en);
    assign exp_we_n  = !(m_active && m_wr && (m_n == 1 || m_n == 2));
    assign exp_addr  = (m_active && m_n == 1) ? {m_w, 1'b0} : (m_active ? {m_w, 1'b1} : m_hold);
    assign exp_dq    = (m_n == 1) ? m_data[15:0] : m_data[31:16];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("m_ready", 32'(ready), 32'(exp_ready));
            chk("m_read_data", read_data, m_rd);
            chk("m_we_n", 32'(sram_we_n), 32'(exp_we_n));
            chk("m_oe_n", 32'(sram_oe_n), 32'(!exp_we_n));
            chk("m_addr", 32'(sram_addr), 32'(exp_addr));
            chk("m_ce_ub_lb", 32'({sram_ce_n, sram_ub_n, sram_lb_n}), 32'd0);
            if (!exp_we_n)
                chk("m_dq", 32'(sram_dq), 32'(exp_dq));
        end
    end

    // Directed access: request held for 'hold' cycles, observed for 'obs' cycles.
    // Address/data are scrambled mid-operation; the latched values must be used.
    logic [31:0] rdy_mask;
    logic [31:0] we_mask;
    logic [15:0] snap_lo [0:15];
    logic [15:0] snap_hi [0:15];

    task automatic run(input bit wr, input bit rd, input logic [31:0] a, input logic [31:0] d,
                       input int hold, input int obs);
        logic [16:0] w;
        w = 17'((a - 32'd1024) >> 2);
        rdy_mask = '0;
        we_mask  = '0;
        for (int k = 0; k < obs; k++) begin
            wr_en = (k < hold) ? wr : 1'b0;
            rd_en = (k < hold) ? rd : 1'b0;
            if (k >= 1 && k <= 5) begin
                address    = ~a;
                write_data = ~d;
            end else begin
                address    = a;
                write_data = d;
            end
            @(negedge clk);
            rdy_mask[k] = ready;
            we_mask[k]  = ~sram_we_n;
            if (k < 16) begin
                snap_lo[k] = sram_mem[idx(w, 1'b0)];
                snap_hi[k] = sram_mem[idx(w, 1'b1)];
            end
            @(posedge clk); #1;
        end
        wr_en = 1'b0;
        rd_en = 1'b0;
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; address = '0; write_data = '0;
        repeat (2) @(posedge clk);
        #1 chk_en = 1'b1;
        @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_read_data", read_data, 32'd0);
        chk("rst_addr", 32'(sram_addr), 32'd0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        @(posedge clk); #1 rst = 1'b0;

        // Idle stretch
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("idle_ready", 32'(ready), 32'd1);
            chk("idle_we_n", 32'(sram_we_n), 32'd1);
        end
        @(posedge clk); #1;

        // Store 0xDEADBEEF at 1028 -> half-words 2 and 3
        run(1'b1, 1'b0, 32'd1028, 32'hDEADBEEF, 7, 9);
        chk("wr_ready_mask", rdy_mask, 32'h1C0);
        chk("wr_we_mask", we_mask, 32'h6);
        chk("wr_lo_c1", 32'(snap_lo[1]), 32'h0);
        chk("wr_lo_c2", 32'(snap_lo[2]), 32'hBEEF);
        chk("wr_hi_c2", 32'(snap_hi[2]), 32'h0);
        chk("wr_hi_c3", 32'(snap_hi[3]), 32'hDEAD);

        // Load it back, then hold through idle cycles
        run(1'b0, 1'b1, 32'd1028, 32'h0, 7, 9);
        chk("rd_ready_mask", rdy_mask, 32'h1C0);
        chk("rd_we_mask", we_mask, 32'h0);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rd_hold", read_data, 32'hDEADBEEF);
        end
        @(posedge clk); #1;

        // Both enables: store wins, load result untouched
        run(1'b1, 1'b1, 32'd1024, 32'h12345678, 7, 9);
        chk("both_ready_mask", rdy_mask, 32'h1C0);
        chk("both_we_mask", we_mask, 32'h6);
        chk("both_read_data", read_data, 32'hDEADBEEF);
        chk("both_mem0", 32'(sram_mem[0]), 32'h5678);
        chk("both_mem1", 32'(sram_mem[1]), 32'h1234);

        // Reset during the wait phase of a load
        rd_en = 1'b1; address = 32'd1028;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
        end
        rst = 1'b1; rd_en = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("wrst_read_data", read_data, 32'd0);
        chk("wrst_ready", 32'(ready), 32'd1);
        chk("wrst_addr", 32'(sram_addr), 32'd0);
        @(posedge clk); #1;
        run(1'b0, 1'b1, 32'd1028, 32'h0, 7, 9);
        chk("wrst_reread", read_data, 32'hDEADBEEF);

        // Back-to-back loads with the request held 14 cycles
        run(1'b0, 1'b1, 32'd1024, 32'h0, 14, 16);
        chk("b2b_ready_mask", rdy_mask, 32'hE040);
        chk("b2b_read_data", read_data, 32'h12345678);

        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
